mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the fetch path (PC unit)
//  and the load/store path (arithmetic_and_memory_unit) of the CPU.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_lat_timer.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 97 +++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and port owner.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/load-store paths, the arbiter and the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester and memory side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_lat_timer.sv
// Loadable down-counter timing the fixed memory latency; done marks the response cycle.
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load) begin
            cnt_d   = CNT_INIT;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) armed_d = 1'b0;
            else             cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign done = armed_q && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// alternating on ties and timing each fixed-latency response.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          we_q, we_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          load, done, arb_pt, win_d;

    assign load = (state_q == ST_ISSUE);

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .done  (done)
    );

    assign arb_pt = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && done);
    // On a tie the requester that did not own the previous access wins.
    assign win_d  = bus.d_req && (!bus.if_req || (last_owner_q == OWN_IF));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if (state_q == ST_ISSUE) state_d = ST_WAIT;
        if (arb_pt) begin
            if (bus.if_req || bus.d_req) begin
                state_d      = ST_ISSUE;
                owner_d      = win_d ? OWN_D : OWN_IF;
                last_owner_d = win_d ? OWN_D : OWN_IF;
                we_d         = win_d && bus.d_we;
                mem_en_d     = 1'b1;
                mem_we_d     = win_d && bus.d_we;
                mem_addr_d   = win_d ? bus.d_addr : bus.if_addr;
                mem_wdata_d  = win_d ? bus.d_wdata : '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.if_gnt    = (state_q == ST_ISSUE) && (owner_q == OWN_IF);
    assign bus.d_gnt     = (state_q == ST_ISSUE) && (owner_q == OWN_D);
    assign bus.if_rvalid = (state_q == ST_WAIT) && done && (owner_q == OWN_IF);
    assign bus.d_rvalid  = (state_q == ST_WAIT) && done && (owner_q == OWN_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (bus.d_rvalid && !we_q) ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table at MEM_LAT=2 plus
// hand-written reset, tie-alternation and MEM_LAT=1 sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) bus2 ();

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        busy;
    } vec_t;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    vec_t vecs [16];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
        bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
        bus2.d_addr = '0; bus2.d_wdata = '0; bus2.mem_rdata = '0;
    endtask

    initial begin
        int   gnt_cyc [$];
        logic gnt_own [$];
        int   overlap;

        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        reset = 1'b1;

        //  fetch  | store  | fetch, then load raised during its WAIT
        vecs[0]  = '{H, 32'h10, L, L, Z, Z, Z,                      L, L, Z, L, L, Z, L, L, Z, Z, L};
        vecs[1]  = '{L, Z, L, L, Z, Z, Z,                           H, L, Z, L, L, Z, H, L, 32'h10, Z, H};
        vecs[2]  = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, L, L, Z, L, L, 32'h10, Z, H};
        vecs[3]  = '{L, Z, L, L, Z, Z, 32'hDEADBEEF,                L, H, 32'hDEADBEEF, L, L, Z, L, L, 32'h10, Z, H};
        vecs[4]  = '{L, Z, H, H, 32'h100, 32'h12345678, Z,          L, L, Z, L, L, Z, L, L, 32'h10, Z, L};
        vecs[5]  = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, H, L, Z, H, H, 32'h100, 32'h12345678, H};
        vecs[6]  = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, L, L, Z, L, L, 32'h100, 32'h12345678, H};
        vecs[7]  = '{L, Z, L, L, Z, Z, 32'hAAAA5555,                L, L, Z, L, H, Z, L, L, 32'h100, 32'h12345678, H};
        vecs[8]  = '{H, 32'h20, L, L, Z, Z, Z,                      L, L, Z, L, L, Z, L, L, 32'h100, 32'h12345678, L};
        vecs[9]  = '{L, Z, L, L, Z, Z, Z,                           H, L, Z, L, L, Z, H, L, 32'h20, Z, H};
        vecs[10] = '{L, Z, H, L, 32'h200, 32'h55, Z,                L, L, Z, L, L, Z, L, L, 32'h20, Z, H};
        vecs[11] = '{L, Z, H, L, 32'h200, 32'h55, 32'hCAFEF00D,     L, H, 32'hCAFEF00D, L, L, Z, L, L, 32'h20, Z, H};
        vecs[12] = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, H, L, Z, H, L, 32'h200, 32'h55, H};
        vecs[13] = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, L, L, Z, L, L, 32'h200, 32'h55, H};
        vecs[14] = '{L, Z, L, L, Z, Z, 32'h600DF00D,                L, L, Z, L, H, 32'h600DF00D, L, L, 32'h200, 32'h55, H};
        vecs[15] = '{L, Z, L, L, Z, Z, Z,                           L, L, Z, L, L, Z, L, L, 32'h200, 32'h55, L};

        // Reset values
        repeat (2) cyc();
        @(negedge clk);
        chk1("rst busy", bus1.busy, 1'b0);
        chk1("rst mem_en", bus1.mem_en, 1'b0);
        chk32("rst mem_addr", bus1.mem_addr, 32'h0);
        chk32("rst mem_wdata", bus1.mem_wdata, 32'h0);
        chk1("rst if_gnt", bus1.if_gnt, 1'b0);
        chk1("rst d_rvalid", bus1.d_rvalid, 1'b0);
        cyc();
        reset = 1'b0;

        // Reset in the middle of a fetch WAIT drops the response
        bus1.if_req = 1'b1;
        bus1.if_addr = 32'h40;
        cyc();
        bus1.if_req = 1'b0;
        @(negedge clk);
        chk1("t1 if_gnt", bus1.if_gnt, 1'b1);
        cyc();
        reset = 1'b1;
        bus1.mem_rdata = 32'h40404040;
        #1;
        chk1("t1 busy after reset", bus1.busy, 1'b0);
        chk32("t1 mem_addr after reset", bus1.mem_addr, 32'h0);
        @(negedge clk);
        chk1("t1 if_rvalid in reset", bus1.if_rvalid, 1'b0);
        cyc();
        @(negedge clk);
        chk1("t1 if_rvalid resp cycle", bus1.if_rvalid, 1'b0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1($sformatf("t1 c%0d mem_en", k), bus1.mem_en, 1'b0);
            chk1($sformatf("t1 c%0d if_rvalid", k), bus1.if_rvalid, 1'b0);
            chk1($sformatf("t1 c%0d busy", k), bus1.busy, 1'b0);
            cyc();
        end
        bus1.mem_rdata = '0;

        // Vector table, one row per clock cycle
        for (int i = 0; i < 16; i++) begin
            bus1.if_req    = vecs[i].if_req;
            bus1.if_addr   = vecs[i].if_addr;
            bus1.d_req     = vecs[i].d_req;
            bus1.d_we      = vecs[i].d_we;
            bus1.d_addr    = vecs[i].d_addr;
            bus1.d_wdata   = vecs[i].d_wdata;
            bus1.mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk1($sformatf("r%0d if_gnt", i), bus1.if_gnt, vecs[i].if_gnt);
            chk1($sformatf("r%0d if_rvalid", i), bus1.if_rvalid, vecs[i].if_rvalid);
            chk32($sformatf("r%0d if_rdata", i), bus1.if_rdata, vecs[i].if_rdata);
            chk1($sformatf("r%0d d_gnt", i), bus1.d_gnt, vecs[i].d_gnt);
            chk1($sformatf("r%0d d_rvalid", i), bus1.d_rvalid, vecs[i].d_rvalid);
            chk32($sformatf("r%0d d_rdata", i), bus1.d_rdata, vecs[i].d_rdata);
            chk1($sformatf("r%0d mem_en", i), bus1.mem_en, vecs[i].mem_en);
            chk1($sformatf("r%0d mem_we", i), bus1.mem_we, vecs[i].mem_we);
            chk32($sformatf("r%0d mem_addr", i), bus1.mem_addr, vecs[i].mem_addr);
            chk32($sformatf("r%0d mem_wdata", i), bus1.mem_wdata, vecs[i].mem_wdata);
            chk1($sformatf("r%0d busy", i), bus1.busy, vecs[i].busy);
            cyc();
        end

        // Both requesters held high from reset: D, IF, D, IF every 3 cycles
        reset = 1'b1;
        clear_inputs();
        bus1.if_req = 1'b1; bus1.if_addr = 32'h400;
        bus1.d_req  = 1'b1; bus1.d_addr  = 32'h800;
        cyc();
        reset = 1'b0;
        overlap = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus1.if_gnt || bus1.d_gnt) begin
                gnt_cyc.push_back(k);
                gnt_own.push_back(bus1.d_gnt);
            end
            if ((bus1.if_gnt && bus1.d_gnt) || ((bus1.if_gnt || bus1.d_gnt) && (bus1.if_rvalid || bus1.d_rvalid)))
                overlap++;
            cyc();
        end
        chk32("t4 overlap count", overlap, 0);
        chk32("t4 grant count", gnt_cyc.size(), 5);
        for (int j = 0; j < 4 && j < gnt_cyc.size(); j++) begin
            chk32($sformatf("t4 g%0d cycle", j), gnt_cyc[j], 1 + 3 * j);
            chk1($sformatf("t4 g%0d owner_is_d", j), gnt_own[j], (j % 2) == 0);
        end

        // MEM_LAT=1 instance with continuous fetch requests
        reset = 1'b1;
        clear_inputs();
        bus2.if_req = 1'b1;
        bus2.if_addr = 32'h80;
        bus2.mem_rdata = 32'h11112222;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1($sformatf("t5 c%0d mem_en", k), bus2.mem_en, (k % 2) == 1);
            chk1($sformatf("t5 c%0d if_rvalid", k), bus2.if_rvalid, (k >= 2) && ((k % 2) == 0));
            chk32($sformatf("t5 c%0d if_rdata", k), bus2.if_rdata,
                  ((k >= 2) && ((k % 2) == 0)) ? 32'h11112222 : 32'h0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
